st2_loader: RTL and testbench

Cartridge image loader between the HPS download stream and port B of the 64 KiB system dual-port RAM. Parses an `.st2` Studio II cartridge image: captures and validates the 256-byte header, then relocates each following 256-byte block to the RAM page named in the header's page table. Holds the CDP1802 in reset while loading and reports completion or error to the top level.

---
 rtl/st2_loader_if.sv | 35 +++
 rtl/st2_loader.sv | 197 +++++++++++++++++++
 tb/tb_st2_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/st2_loader_if.sv
`default_nettype none
// ============================================================================
// st2_loader_if : HPS download stream, RAM port B and loader status bundle.
// Rev 1.0
// ============================================================================
interface st2_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;

  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [1:0]  err_code;
  logic        page_fault;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  mem_wr, mem_addr, mem_din,
    input  cpu_hold, load_done, load_error, err_code, page_fault
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output mem_wr, mem_addr, mem_din,
    output cpu_hold, load_done, load_error, err_code, page_fault
  );
endinterface
`default_nettype wire

// File: rtl/st2_loader.sv
`default_nettype none
// ============================================================================
// st2_loader : .st2 Studio II cartridge loader, HPS download -> RAM port B.
// Raw binary mode is built when ST2_LOADER_RAW_BIN_EN is defined.
// Rev 1.0
// ============================================================================
module st2_loader #(
  parameter logic [7:0]  ST2_INDEX = 8'h01,
  parameter logic [7:0]  RAW_INDEX = 8'h02,
  parameter logic [15:0] RAW_BASE  = 16'h0400
) (
  input  logic        clk,
  input  logic        reset,
  st2_loader_if.slave bus_io
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_BODY   = 3'd2,
    S_RAW    = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  localparam logic [1:0] c_err_none  = 2'd0;
  localparam logic [1:0] c_err_magic = 2'd1;
  localparam logic [1:0] c_err_nblk  = 2'd2;
  localparam logic [1:0] c_err_short = 2'd3;

  state_e      state_q, state_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        dl_q;
  logic        magic_ok_q;
  logic [7:0]  nblk_q;
  logic [7:0]  pt_q [64];
  logic        mem_wr_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_din_q;
  logic        cpu_hold_q, load_done_q, load_error_q, page_fault_q;

  logic        w_rise, w_fall, w_wr_ok;
  logic        w_start_st2, w_start_raw, w_start;
  logic        w_hdr_wr, w_hdr_end;
  logic [1:0]  w_hdr_code;
  logic [5:0]  w_blk;
  logic [7:0]  w_page;
  logic        w_body_in, w_body_wr, w_body_fault;
  logic        w_raw_wr;
  logic [15:0] w_raw_addr;
  logic        w_hold_d;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h52;
      2'd1:    return 8'h43;
      2'd2:    return 8'h41;
      default: return 8'h32;
    endcase
  endfunction

  always_comb begin
    w_rise  = bus_io.ioctl_download & ~dl_q;
    w_fall  = ~bus_io.ioctl_download & dl_q;
    // A strobe coinciding with the falling edge still counts: dl_q covers that cycle.
    w_wr_ok = bus_io.ioctl_wr & (bus_io.ioctl_download | dl_q);

    w_start_st2 = w_rise && (bus_io.ioctl_index == ST2_INDEX);
`ifdef ST2_LOADER_RAW_BIN_EN
    w_start_raw = w_rise && (bus_io.ioctl_index == RAW_INDEX) && !w_start_st2;
`else
    w_start_raw = 1'b0;
`endif
    w_start = w_start_st2 | w_start_raw;

    w_hdr_wr  = w_wr_ok && (state_q == S_HEADER) && (bus_io.ioctl_addr[24:8] == 17'd0);
    w_hdr_end = w_hdr_wr && (bus_io.ioctl_addr[7:0] == 8'hFF);

    if (!magic_ok_q)
      w_hdr_code = c_err_magic;
    else if ((nblk_q < 8'd2) || (nblk_q > 8'd65))
      w_hdr_code = c_err_nblk;
    else
      w_hdr_code = c_err_none;

    w_blk        = bus_io.ioctl_addr[13:8] - 6'd1;
    w_page       = pt_q[w_blk];
    w_body_in    = (bus_io.ioctl_addr[24:14] == 11'd0) &&
                   ({2'b00, bus_io.ioctl_addr[13:8]} < nblk_q);
    w_body_wr    = w_wr_ok && (state_q == S_BODY) && w_body_in && (w_page >= 8'h04);
    w_body_fault = w_wr_ok && (state_q == S_BODY) && w_body_in && (w_page < 8'h04);

    w_raw_addr = RAW_BASE + bus_io.ioctl_addr[15:0];
    w_raw_wr   = w_wr_ok && (state_q == S_RAW) && (bus_io.ioctl_addr[24:16] == 9'd0);
  end

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      S_HEADER: begin
        if (w_hdr_end) begin
          if (w_hdr_code != c_err_none) begin
            state_d    = S_ERROR;
            err_code_d = w_hdr_code;
          end else if (w_fall) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BODY;
          end
        end else if (w_fall) begin
          state_d    = S_ERROR;
          err_code_d = c_err_short;
        end
      end
      S_BODY, S_RAW: begin
        if (w_fall) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase
    // Unknown indices leave the current state (and any error report) untouched.
    if (w_start_st2) begin
      state_d    = S_HEADER;
      err_code_d = c_err_none;
    end else if (w_start_raw) begin
      state_d    = S_RAW;
      err_code_d = c_err_none;
    end
    w_hold_d = (state_d == S_HEADER) || (state_d == S_BODY) ||
               (state_d == S_RAW)    || (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      err_code_q   <= c_err_none;
      // Track the live level so a download still in progress is not seen as a new start.
      dl_q         <= bus_io.ioctl_download;
      magic_ok_q   <= 1'b0;
      nblk_q       <= 8'h00;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_din_q    <= 8'h00;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      page_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      dl_q         <= bus_io.ioctl_download;
      cpu_hold_q   <= w_hold_d;
      load_done_q  <= (state_q == S_DONE);
      load_error_q <= (state_d == S_ERROR);
      mem_wr_q     <= w_body_wr | w_raw_wr;

      if (w_body_wr) begin
        mem_addr_q <= {w_page, bus_io.ioctl_addr[7:0]};
        mem_din_q  <= bus_io.ioctl_dout;
      end else if (w_raw_wr) begin
        mem_addr_q <= w_raw_addr;
        mem_din_q  <= bus_io.ioctl_dout;
      end

      if (w_start)
        page_fault_q <= 1'b0;
      else if (w_body_fault)
        page_fault_q <= 1'b1;

      if (w_start_st2)
        magic_ok_q <= 1'b1;
      else if (w_hdr_wr && (bus_io.ioctl_addr[7:2] == 6'd0) &&
               (bus_io.ioctl_dout != magic_byte(bus_io.ioctl_addr[1:0])))
        magic_ok_q <= 1'b0;

      if (w_hdr_wr && (bus_io.ioctl_addr[7:0] == 8'd4))
        nblk_q <= bus_io.ioctl_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hdr_wr && (bus_io.ioctl_addr[7:6] == 2'b01))
      pt_q[bus_io.ioctl_addr[5:0]] <= bus_io.ioctl_dout;
  end

  assign bus_io.mem_wr     = mem_wr_q;
  assign bus_io.mem_addr   = mem_addr_q;
  assign bus_io.mem_din    = mem_din_q;
  assign bus_io.cpu_hold   = cpu_hold_q;
  assign bus_io.load_done  = load_done_q;
  assign bus_io.load_error = load_error_q;
  assign bus_io.err_code   = err_code_q;
  assign bus_io.page_fault = page_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_st2_loader.sv
`default_nettype none
// tb_st2_loader : randomized .st2 / raw downloads checked against a file-level model
// of where each byte must land in RAM and how each download must end.
module tb_st2_loader;

  localparam logic [7:0]  ST2_IDX  = 8'h01;
  localparam logic [7:0]  RAW_IDX  = 8'h02;
  localparam logic [15:0] RAW_BASE = 16'h0400;

  logic clk = 1'b0;
  logic reset = 1'b1;

  st2_loader_if bus ();

  st2_loader #(
    .ST2_INDEX (ST2_IDX),
    .RAW_INDEX (RAW_IDX),
    .RAW_BASE  (RAW_BASE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed RAM writes and load_done pulses, sampled mid-cycle.
  logic [23:0] obs_q[$];
  int done_cnt = 0;
  int last_wr_cyc = 0;
  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      obs_q.push_back({bus.mem_addr, bus.mem_din});
      last_wr_cyc <= cyc;
    end
    if (bus.load_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  logic [7:0]  file_b [0:2047];
  logic [23:0] exp_q[$];
  logic [1:0]  exp_err = 2'd0;
  logic        exp_fault = 1'b0;
  logic        exp_hold = 1'b0;
  int          exp_done = 0;
  logic [3:0]  ld_trace;
  logic        hold_last;
  int          last_byte_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_st2(input logic [31:0] magic, input int nblk,
                           input logic [7:0] p0, input logic [7:0] p1, input int len);
    for (int i = 0; i < len; i++) file_b[i] = 8'($urandom);
    file_b[0] = magic[31:24];
    file_b[1] = magic[23:16];
    file_b[2] = magic[15:8];
    file_b[3] = magic[7:0];
    file_b[4] = 8'(nblk);
    for (int j = 64; j < 128; j++) file_b[j] = 8'($urandom_range(4, 255));
    file_b[64] = p0;
    file_b[65] = p1;
  endtask

  // Reference: header rules and block relocation computed per file offset.
  task automatic model(input logic [7:0] idx, input int len, input int reset_at);
    int eff;
    int blk;
    int nblk;
    logic [7:0] page;
    logic magic_ok;
    exp_q.delete();
    exp_done = 0;
    if (idx == ST2_IDX) begin
      exp_err   = 2'd0;
      exp_fault = 1'b0;
      exp_hold  = 1'b1;
      nblk      = int'(file_b[4]);
      magic_ok  = (file_b[0] == 8'h52) && (file_b[1] == 8'h43) &&
                  (file_b[2] == 8'h41) && (file_b[3] == 8'h32);
      eff       = (reset_at >= 0) ? reset_at : len;
      if (reset_at < 0 && len < 256) exp_err = 2'd3;
      else if (reset_at < 0 && !magic_ok) exp_err = 2'd1;
      else if (reset_at < 0 && (nblk < 2 || nblk > 65)) exp_err = 2'd2;
      else begin
        for (int off = 256; off < eff; off++) begin
          blk = off / 256;
          if (off < 16384 && blk < nblk) begin
            page = file_b[64 + blk - 1];
            if (page < 8'h04) exp_fault = 1'b1;
            else exp_q.push_back({page, 8'(off % 256), file_b[off]});
          end
        end
        exp_hold = 1'b0;
        if (reset_at >= 0) exp_fault = 1'b0;
        else exp_done = 1;
      end
    end
`ifdef ST2_LOADER_RAW_BIN_EN
    else if (idx == RAW_IDX) begin
      exp_err   = 2'd0;
      exp_fault = 1'b0;
      exp_hold  = 1'b0;
      exp_done  = 1;
      for (int off = 0; off < len; off++)
        exp_q.push_back({16'(RAW_BASE + off), file_b[off]});
    end
`endif
  endtask

  task automatic run(input logic [7:0] idx, input int len, input int reset_at, input bit coincide);
    bus.ioctl_index = idx;
    @(posedge clk); #1;
    bus.ioctl_download = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = file_b[i];
      reset          = (i == reset_at);
      if (coincide && i == len - 1) bus.ioctl_download = 1'b0;
      if (i == len - 1) last_byte_cyc = cyc;
    end
    if (!coincide) begin
      @(posedge clk); #1;
      bus.ioctl_wr = 1'b0;
      reset = 1'b0;
      bus.ioctl_download = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bus.ioctl_wr = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      ld_trace[k] = bus.load_done;
      hold_last   = bus.cpu_hold;
    end
  endtask

  task automatic scenario(input string tag, input logic [7:0] idx, input int len,
                          input int reset_at, input bit coincide, input bit chk_lat);
    int start;
    int done0;
    int nobs;
    int f0;
    start = obs_q.size();
    done0 = done_cnt;
    model(idx, len, reset_at);
    run(idx, len, reset_at, coincide);
    nobs = obs_q.size() - start;
    check({tag, ".nwr"}, 32'(nobs), 32'(exp_q.size()));
    for (int i = 0; i < nobs && i < exp_q.size(); i++) begin
      f0 = fails;
      check({tag, ".wr"}, 32'(obs_q[start + i]), 32'(exp_q[i]));
      if (fails != f0) break;
    end
    check({tag, ".done_cnt"}, 32'(done_cnt - done0), 32'(exp_done));
    check({tag, ".done_timing"}, 32'(ld_trace), (exp_done != 0) ? 32'h2 : 32'h0);
    check({tag, ".err_code"}, 32'(bus.err_code), 32'(exp_err));
    check({tag, ".load_error"}, 32'(bus.load_error), 32'(exp_err != 2'd0));
    check({tag, ".page_fault"}, 32'(bus.page_fault), 32'(exp_fault));
    check({tag, ".cpu_hold"}, 32'(hold_last), 32'(exp_hold));
    if (chk_lat) check({tag, ".wr_latency"}, 32'(last_wr_cyc - last_byte_cyc), 32'd1);
  endtask

  initial begin
    int nb;
    int ln;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'h00;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 25'd0;
    bus.ioctl_dout     = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst.mem_wr",     32'(bus.mem_wr),     32'd0);
    check("rst.mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst.mem_din",    32'(bus.mem_din),    32'd0);
    check("rst.cpu_hold",   32'(bus.cpu_hold),   32'd0);
    check("rst.load_done",  32'(bus.load_done),  32'd0);
    check("rst.load_error", 32'(bus.load_error), 32'd0);
    check("rst.err_code",   32'(bus.err_code),   32'd0);
    check("rst.page_fault", 32'(bus.page_fault), 32'd0);

    build_st2("RCA2", 3, 8'h04, 8'h06, 768);
    scenario("valid3", ST2_IDX, 768, -1, 1'b0, 1'b1);

    build_st2("RCA2", 3, 8'h04, 8'h06, 768);
    scenario("unk_idx", 8'h07, 768, -1, 1'b0, 1'b0);

    build_st2("RCA3", 3, 8'h04, 8'h06, 512);
    scenario("bad_magic", ST2_IDX, 512, -1, 1'b0, 1'b0);

    build_st2("RCA2", 3, 8'h04, 8'h06, 100);
    scenario("short", ST2_IDX, 100, -1, 1'b0, 1'b0);

    build_st2("RCA2", 66, 8'h04, 8'h06, 512);
    scenario("nblk66", ST2_IDX, 512, -1, 1'b0, 1'b0);

    build_st2("RCA2", 1, 8'h04, 8'h06, 512);
    scenario("nblk1", ST2_IDX, 512, -1, 1'b0, 1'b0);

    build_st2("RCA2", 3, 8'h02, 8'h05, 768);
    scenario("pfault", ST2_IDX, 768, -1, 1'b1, 1'b0);

    build_st2("RCA2", 2, 8'h04, 8'h06, 1024);
    scenario("nblk2", ST2_IDX, 1024, -1, 1'b0, 1'b0);

    build_st2("RCA2", 3, 8'h04, 8'h06, 768);
    scenario("reset_mid", ST2_IDX, 768, 300, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      nb = $urandom_range(2, 6);
      ln = $urandom_range(256, 256 * (nb + 1));
      build_st2("RCA2", nb, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), ln);
      for (int j = 66; j < 128; j++) file_b[j] = 8'($urandom_range(0, 15));
      scenario("random", ST2_IDX, ln, -1, r[0], 1'b0);
    end

    for (int i = 0; i < 16; i++) file_b[i] = 8'($urandom);
    scenario("raw16", RAW_IDX, 16, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
